// File: rtl/cs_pkg.sv
// Shared definitions for the CS result path.
// Holds the default result width and window length, the warm-up state
// encoding, and the occupancy-counter width helper.
package cs_pkg;

  localparam int unsigned CS_DW  = 10;
  localparam int unsigned CS_WIN = 9;

  typedef enum logic {
    FILL,
    RUN
  } warm_state_e;

  // Occupancy counter needs to represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cs_result_buffer_if.sv
// Result-stream and host-handshake bundle for cs_result_buffer.
//   y_in/y_en          : result stream from the CS stage
//   out_data/out_valid : head-of-FIFO result towards the host
//   out_ready          : host accepts out_data this cycle
// master = producer/host side, slave = the buffer.
interface cs_result_buffer_if #(
  parameter int unsigned DW = cs_pkg::CS_DW
);

  logic [DW-1:0] y_in;
  logic          y_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output y_in, y_en, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  y_in, y_en, out_ready,
    output out_data, out_valid
  );

endinterface

// File: rtl/cs_rbuf_fifo.sv
// Generic synchronous show-ahead FIFO.
//   clk, rst_ni : clock, synchronous active-low reset
//   wr_en_i/wr_data_i : push request and data (ignored when full unless popping)
//   rd_en_i           : pop request (ignored when empty)
//   rd_data_o         : head entry; holds the last popped value while empty
//   full_o/empty_o/count_o : occupancy status
module cs_rbuf_fifo
  import cs_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = CS_DW
) (
  input  logic                          clk,
  input  logic                          rst_ni,
  input  logic                          wr_en_i,
  input  logic [DW-1:0]                 wr_data_i,
  input  logic                          rd_en_i,
  output logic [DW-1:0]                 rd_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [DW-1:0] last_q;
  logic          rd_ok, wr_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  // A pop in the same cycle frees a slot, so a push into a full FIFO succeeds.
  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_ok);

  // While empty, present the last popped value instead of stale RAM contents.
  assign rd_data_o = empty_o ? last_q : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cs_result_buffer.sv
// CS result buffer: drops the first WARMUP result strobes after reset, then
// queues results in a show-ahead FIFO for the host with sticky overflow.
//   clk, reset : clock, synchronous active-low reset
//   bus        : y_in/y_en in, out_data/out_valid out, out_ready in
//   count      : FIFO occupancy 0..DEPTH
//   warm       : warm-up complete, strobes are now stored
//   overflow   : sticky, a result was dropped on a full FIFO
//   peak       : (CS_RBUF_PEAK_EN only) unsigned max of stored results
// Optional feature macro: CS_RBUF_PEAK_EN.
module cs_result_buffer
  import cs_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WARMUP = CS_WIN,
  parameter int unsigned DW     = CS_DW
) (
  input  logic                        clk,
  input  logic                        reset,
  cs_result_buffer_if.slave           bus,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        warm,
`ifdef CS_RBUF_PEAK_EN
  output logic [DW-1:0]               peak,
`endif
  output logic                        overflow
);

  localparam int unsigned WCW = $clog2(WARMUP + 1);

  warm_state_e    state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           ovf_q;
  logic           full, empty;
  logic           rd_en, wr_req, wr_accept;

  // Warm-up FSM: state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FILL;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Warm-up FSM: next state. The WARMUP-th strobe moves to RUN but is not stored.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (state_q == FILL && bus.y_en) begin
      if (wcnt_q == WCW'(WARMUP - 1)) begin
        state_d = RUN;
      end else begin
        wcnt_d = wcnt_q + WCW'(1);
      end
    end
  end

  // Warm-up FSM: outputs.
  always_comb begin
    warm = (state_q == RUN);
  end

  assign bus.out_valid = !empty;
  assign rd_en         = bus.out_valid && bus.out_ready;
  assign wr_req        = bus.y_en && warm;
  assign wr_accept     = wr_req && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (wr_req && full && !rd_en) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;

`ifdef CS_RBUF_PEAK_EN
  logic [DW-1:0] peak_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      peak_q <= '0;
    end else if (wr_accept && (bus.y_in > peak_q)) begin
      peak_q <= bus.y_in;
    end
  end

  assign peak = peak_q;
`endif

  cs_rbuf_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst_ni    (reset),
    .wr_en_i   (wr_accept),
    .wr_data_i (bus.y_in),
    .rd_en_i   (rd_en),
    .rd_data_o (bus.out_data),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count)
  );

endmodule

// File: doc/cs_result_buffer.md
Name: cs_result_buffer

Overview:
- Downstream stage of the CS computational system; consumes the 10-bit Y result stream produced once per accepted X sample.
- Discards warm-up results produced before the 9-sample window is full.
- Buffers valid results in a small FIFO and delivers them to the host over a valid/ready handshake, with sticky overflow reporting.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- WARMUP, 9, number of y_en strobes discarded after reset (window length).
- DW, 10, result width; matches the CS Y output.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- y_in  in  DW  result from the CS stage.
- y_en  in  1  y_in is a new result this cycle; one strobe per X sample.
- out_data  out  DW  head-of-FIFO result.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  host accepts out_data this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- warm  out  1  warm-up complete; subsequent strobes are stored.
- overflow  out  1  sticky; a result was dropped because the FIFO was full.

Behaviour:
- Reset (reset==0 at posedge): count=0, out_valid=0, out_data=0, warm=0, overflow=0; read/write pointers=0; warm-up counter=0. Reset takes priority over every other event and may be asserted mid-transfer; entries in flight are lost.
- Warm-up state machine has two states:
  - FILL: each y_en increments the warm-up counter; no write occurs. On the WARMUP-th strobe, transition to RUN and assert warm from the next cycle. The WARMUP-th strobe itself is discarded.
  - RUN: each y_en writes y_in to the FIFO. The block stays in RUN until reset.
- Write: allowed when y_en && warm && (count<DEPTH). If the FIFO is full, the write is dropped and overflow is set. overflow is cleared only by reset.
- Read: occurs when out_valid && out_ready; the read pointer advances.
- out_data is the combinational head entry (registered RAM read with show-ahead). When the FIFO is empty, out_data holds its last value (0 after reset).
- out_valid = (count!=0). First-word latency: a value written at edge N is visible with out_valid=1 after edge N.
- Simultaneous read and write:
  - When not full: count unchanged, both pointers advance.
  - When full: the read frees a slot in the same cycle, so the write succeeds and no overflow is flagged.
  - When empty: the write succeeds, no read occurs (out_valid was 0), and count becomes 1.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. count is tracked separately to disambiguate full from empty.
- y_in is stored unmodified; no arithmetic on data.
- out_ready while out_valid==0 is ignored.

Optional Feature:
- Macro CS_RBUF_PEAK_EN.
- With the macro defined:
  - Adds output peak [DW-1:0], the maximum y_in written to the FIFO since reset.
  - Updates in the same cycle as the write (visible after the edge).
  - Resets to 0. Comparison is unsigned. Dropped (overflow) and warm-up samples do not update peak.
- Without the macro: port and logic are absent, and the block is otherwise identical.

Decomposition:
- Shared package cs_pkg holds:
  - CS_DW=10, CS_WIN=9 constants.
  - The warm-up state enum {FILL, RUN}.
  - The count width function.
- One sub-module, cs_rbuf_fifo: a generic synchronous show-ahead FIFO (DEPTH, DW) with wr_en/rd_en/full/empty/count. The top level adds the warm-up FSM, overflow, and peak logic.

Test Plan:
- Reset, then 9 y_en strobes with y_in=1..9, then 3 strobes with y_in=100,101,102 and out_ready=0 -> warm rises after the 9th strobe; count=3; out_data=100; no warm-up value is stored.
- After warm-up, 10 strobes (y_in=200..209) with out_ready=0, DEPTH=8 -> count=8; overflow=1 after the 9th write; drain yields exactly 200..207 in order.
- Full FIFO, one cycle with y_en=1, y_in=555 and out_ready=1 -> head popped, 555 stored, count stays 8, overflow stays 0.
- Continuous streaming with y_en=1 and out_ready=1 every cycle for 20 values after warm-up, wrapping the pointers twice -> output order is identical to input, count never exceeds 1, out_valid is steady.
- Assert reset=0 for one cycle with count=5 and warm=1 -> count=0, out_valid=0, warm=0, overflow=0; the next 9 strobes are discarded again.
- With CS_RBUF_PEAK_EN defined: after warm-up write 300, 1023, 50, and hit overflow on a value of 1000 with the FIFO full -> peak=1023; values 5..9 during warm-up never affect peak.
